// File: rtl/agex_hazard_ctrl.sv
// AGEX issue controller: RAW countdown scoreboard, redirect flush sequencing and stall/flush counters.
// Optional write-back bypass is enabled by defining AGEX_HAZARD_WB_BYPASS_EN.
module agex_hazard_ctrl #(
  parameter int REGNOBITS    = 5,
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_rs1_used,
  input  logic                 de_rs2_used,
  input  logic [REGNOBITS-1:0] de_rd,
  input  logic                 de_wr_reg,
  input  logic                 agex_br_taken,
  output logic                 issue,
  output logic                 stall_de,
  output logic                 flush_de,
  output logic                 flush_fe,
  output logic [31:0]          stall_cnt,
  output logic [15:0]          flush_cnt
);

  localparam int         NREGS      = 1 << REGNOBITS;
  localparam logic [1:0] DEPTH_V    = 2'(DEPTH);
  localparam logic [1:0] FLUSH_V    = 2'(FLUSH_CYCLES);
  localparam bit         HAS_SQUASH = (FLUSH_CYCLES != 0);

  typedef enum logic [0:0] {IDLE = 1'b0, SQUASH = 1'b1} state_t;

  state_t     state;
  logic [1:0] fcnt;
  logic [1:0] sb [NREGS];
  logic       hazard;
  logic       redirect;

  function automatic logic busy(input logic [1:0] v);
`ifdef AGEX_HAZARD_WB_BYPASS_EN
    // A count of 1 means WB writes the regfile early enough for DE to read it.
    return (v > 2'd1);
`else
    return (v != 2'd0);
`endif
  endfunction

  assign hazard = (de_rs1_used && (de_rs1 != '0) && busy(sb[de_rs1])) ||
                  (de_rs2_used && (de_rs2 != '0) && busy(sb[de_rs2]));

  assign redirect = reset && (state == IDLE) && agex_br_taken;

  // Issue/stall/flush decode from current state and DE inputs.
  always_comb begin
    issue    = 1'b0;
    stall_de = 1'b0;
    flush_de = 1'b1;
    flush_fe = 1'b0;
    if (!reset) begin
      issue = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (agex_br_taken) begin
            flush_fe = 1'b1;
          end else if (de_valid && hazard) begin
            stall_de = 1'b1;
          end else if (de_valid) begin
            issue    = 1'b1;
            flush_de = 1'b0;
          end else begin
            flush_de = 1'b1;
          end
        end
        SQUASH: begin
          flush_de = 1'b1;
        end
        default: begin
          flush_de = 1'b1;
        end
      endcase
    end
  end

  // Flush sequencer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      fcnt  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect && HAS_SQUASH) begin
            state <= SQUASH;
            fcnt  <= FLUSH_V;
          end else begin
            state <= IDLE;
            fcnt  <= fcnt;
          end
        end
        SQUASH: begin
          fcnt <= fcnt - 2'd1;
          if (fcnt <= 2'd1) begin
            state <= IDLE;
          end else begin
            state <= SQUASH;
          end
        end
        default: begin
          state <= IDLE;
          fcnt  <= 2'd0;
        end
      endcase
    end
  end

  // Scoreboard: a new producer reload wins over the per-cycle countdown.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (!reset || (r == 0)) begin
        sb[r] <= 2'd0;
      end else if (issue && de_wr_reg && (de_rd == REGNOBITS'(r))) begin
        sb[r] <= DEPTH_V;
      end else if (sb[r] != 2'd0) begin
        sb[r] <= sb[r] - 2'd1;
      end else begin
        sb[r] <= sb[r];
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_de && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (redirect && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: doc/agex_hazard_ctrl.md
# agex_hazard_ctrl

Issue controller for the AGEX stage. Sits between DE and AGEX and decides each cycle whether the DE instruction issues into AGEX, stalls in DE, or is squashed. Holds a per-register countdown scoreboard for RAW hazards and a flush state machine that sequences recovery after a taken branch or jump redirect from AGEX. Keeps stall and flush statistics counters for performance debug.

## Interface

Parameters:
- `REGNOBITS`, 5: register-number width; the scoreboard has 2^REGNOBITS entries.
- `DEPTH`, 3: cycles from AGEX entry to regfile write in WB. Legal range 1..3.
- `FLUSH_CYCLES`, 1: extra issue-blocked cycles after the redirect cycle. Legal range 0..3.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `de_valid`  in  1  DE holds a valid instruction.
- `de_rs1`, `de_rs2`  in  REGNOBITS  source registers.
- `de_rs1_used`, `de_rs2_used`  in  1  the source is actually read.
- `de_rd`  in  REGNOBITS  destination register.
- `de_wr_reg`  in  1  the instruction writes `de_rd`.
- `agex_br_taken`  in  1  the instruction in AGEX redirects the PC (valid-qualified).
- `issue`  out  1  the DE instruction enters the AGEX latch this edge.
- `stall_de`  out  1  DE and FE hold their contents.
- `flush_de`  out  1  a bubble is written into the AGEX latch instead of the DE contents.
- `flush_fe`  out  1  the FE/DE latch is invalidated.
- `stall_cnt`  out  32  saturating count of `stall_de` cycles.
- `flush_cnt`  out  16  saturating count of accepted redirects.

## Operation

- Scoreboard: one 2-bit counter `sb[r]` per register.
  - On an `issue` edge with `de_wr_reg` set and `de_rd`≠0: `sb[de_rd]` ← `DEPTH`.
  - On every edge, every other nonzero `sb[r]` decrements by 1.
  - Set has priority over decrement for the same register.
  - `sb[0]` is always 0.
- Hazard: `(de_rs1_used & de_rs1≠0 & busy(de_rs1)) | (de_rs2_used & de_rs2≠0 & busy(de_rs2))`.
  - `busy(r)` = `sb[r]≠0`.
  - With the bypass option enabled (see Configuration), `busy(r)` = `sb[r]>1`.
- State machine:
  - IDLE:
    - If `agex_br_taken`: `flush_de`=1, `flush_fe`=1, `issue`=0, `stall_de`=0, `flush_cnt`+1. Go to SQUASH with `fcnt`←`FLUSH_CYCLES`, or stay in IDLE if `FLUSH_CYCLES`=0.
    - Else if `de_valid` & hazard: `stall_de`=1, `flush_de`=1 (bubble), `stall_cnt`+1.
    - Else: `issue`=`de_valid`. If `de_valid`=0, then `flush_de`=1.
  - SQUASH: `flush_de`=1, `issue`=0, `stall_de`=0, `flush_fe`=0. `fcnt` decrements each cycle; go to IDLE when `fcnt`=1. `agex_br_taken` is ignored here, because AGEX holds only bubbles.
- Redirect outranks hazard in the same cycle: there is no stall, and `stall_cnt` does not increment.
- Counters saturate at all-ones.
- Reset (`reset`=0 sampled on an edge):
  - All `sb`←0, state←IDLE, `fcnt`←0, `stall_cnt`←0, `flush_cnt`←0.
  - While `reset`=0, outputs are forced to `issue`=0, `stall_de`=0, `flush_fe`=0, `flush_de`=1.
  - Reset mid-SQUASH or mid-stall aborts immediately.

## Timing

- `issue`, `stall_de`, `flush_de`, `flush_fe` are combinational from registered state and current inputs. Zero-cycle latency.
- `stall_cnt` and `flush_cnt` are registered and update on the edge that closes the counted cycle.
- Producer issued at edge t (`DEPTH`=3): `sb`=3,2,1 in cycles t+1..t+3, then 0.
  - A dependent instruction in DE at t+1 stalls t+1..t+3 and issues at t+4.
  - With bypass enabled, it issues at t+3.
- Redirect in cycle c (`FLUSH_CYCLES`=1): bubbles enter AGEX at c and c+1. The first possible issue is in cycle c+2.

## Configuration

- `AGEX_HAZARD_WB_BYPASS_EN`
  - Defined: the regfile writes in the first half of the WB cycle. `sb`=1 is not a hazard, which saves one stall cycle per dependency.
  - Undefined: any nonzero `sb` is a hazard.

## Test plan

- Reset: hold `reset`=0 for 2 cycles with `de_valid`=1 → `issue`=0, `flush_de`=1, both counters 0, and all `sb` entries 0 after release.
- RAW stall: issue ADD x5 at t, then SUB rs1=x5 in DE at t+1 → `stall_de`=1 for 3 cycles (2 with bypass), issue at t+4 (t+3), `stall_cnt`=3 (2).
- x0 and unused sources: producer writes x0, consumer reads x0; LUI with `de_rs1_used`=0 reading x5 while x5 is busy → no stall in either case.
- Redirect during hazard: `agex_br_taken`=1 while DE is stalled → `flush_fe`=1, `flush_de`=1, `stall_de`=0, `flush_cnt`=1, `stall_cnt` unchanged, SQUASH for 1 cycle.
- Squash window: `agex_br_taken` asserted during SQUASH → ignored, `flush_cnt` unchanged, IDLE after `FLUSH_CYCLES`.
- Back-to-back writers: x7 issued at t and again at t+1 → `sb[x7]` reloads to 3, and the consumer stalls until t+5 (t+4 with bypass).
